wb_data_sel_seq: RTL

// - Parametrised, registered successor to the MIPS write-back data mux.
// - Selects the register-file write data D from one of four sources: ALU result, data-memory load, PC link, or immediate.
// - Aligns and extends sub-word loads; waits for a variable-latency data memory through a valid/ready handshake.
// - Flags misaligned loads and memory timeouts.
// - Sits between EX/MEM and the register-file write port.

---
 rtl/wb_data_sel_seq_pkg.sv | 26 ++
 rtl/wb_data_sel_seq_load_extend.sv | 40 ++++
 rtl/wb_data_sel_seq.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/wb_data_sel_seq_pkg.sv
// Shared types and default widths for the registered write-back data selector.
// Selector, load-size and FSM state encodings live here.
package wb_data_sel_seq_pkg;

  localparam int N  = 32;
  localparam int Pb = 32;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_MEM  = 2'd1,
    WB_LINK = 2'd2,
    WB_IMM  = 2'd3
  } wb_sel_t;

  typedef enum logic [1:0] {
    LD_B = 2'd0,
    LD_H = 2'd1,
    LD_W = 2'd2
  } ld_size_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1
  } wb_state_t;

endpackage

// File: rtl/wb_data_sel_seq_load_extend.sv
// Combinational sub-word load alignment and sign/zero extension.
// Also flags misaligned half and word accesses.
module load_extend #(
  parameter int N = wb_data_sel_seq_pkg::N
) (
  input  logic [N-1:0] dm_q,
  input  logic [1:0]   ld_size,
  input  logic         ld_uns,
  input  logic [1:0]   addr_lo,
  output logic [N-1:0] ext_q,
  output logic         misalign
);
  import wb_data_sel_seq_pkg::*;

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = dm_q[{addr_lo, 3'b000} +: 8];
  assign half_v = dm_q[{addr_lo[1], 4'b0000} +: 16];

  // The unused size encoding behaves as a full word access.
  always_comb begin
    ext_q    = dm_q;
    misalign = 1'b0;
    case (ld_size_t'(ld_size))
      LD_B: begin
        ext_q = ld_uns ? N'(byte_v) : {{(N-8){byte_v[7]}}, byte_v};
      end
      LD_H: begin
        ext_q    = ld_uns ? N'(half_v) : {{(N-16){half_v[15]}}, half_v};
        misalign = addr_lo[0];
      end
      default: begin
        ext_q    = dm_q;
        misalign = (addr_lo != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/wb_data_sel_seq.sv
// Registered write-back data selector with a variable-latency load path.
// Waits on dm_valid with a bounded timeout and flags misaligned loads.
module wb_data_sel_seq #(
  parameter int          N        = wb_data_sel_seq_pkg::N,
  parameter int          Pb       = wb_data_sel_seq_pkg::Pb,
  parameter int unsigned LINK_OFS = 4,
  parameter int unsigned TMO      = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    sel,
  input  logic [1:0]    ld_size,
  input  logic          ld_uns,
  input  logic [1:0]    addr_lo,
  input  logic [4:0]    rd_in,
  input  logic          we_in,
  input  logic [Pb-1:0] PC,
  input  logic [N-1:0]  R,
  input  logic [N-1:0]  imm,
  input  logic [N-1:0]  dm_q,
  input  logic          dm_valid,
  output logic [N-1:0]  D,
  output logic          D_valid,
  output logic [4:0]    rd_out,
  output logic          we_out,
  output logic          err,
  output logic          busy
);
  import wb_data_sel_seq_pkg::*;

  wb_state_t    state_q, state_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [1:0]   size_q, size_d;
  logic [1:0]   addr_q, addr_d;
  logic         uns_q, uns_d;
  logic [4:0]   lrd_q, lrd_d;
  logic         lwe_q, lwe_d;

  logic [N-1:0] d_d;
  logic [4:0]   rd_d;
  logic         we_d, dv_d, err_d;

  logic [Pb-1:0] link_pc;
  logic [N-1:0]  link_val, sel_val, ext_q;
  logic          misalign;

  assign link_pc  = PC + Pb'(LINK_OFS);
  assign link_val = N'(link_pc);

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q == WAIT_MEM);

  load_extend #(.N(N)) u_load_extend (
    .dm_q     (dm_q),
    .ld_size  (size_q),
    .ld_uns   (uns_q),
    .addr_lo  (addr_q),
    .ext_q    (ext_q),
    .misalign (misalign)
  );

  always_comb begin
    sel_val = R;
    case (wb_sel_t'(sel))
      WB_LINK: sel_val = link_val;
      WB_IMM:  sel_val = imm;
      default: sel_val = R;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    size_d  = size_q;
    addr_d  = addr_q;
    uns_d   = uns_q;
    lrd_d   = lrd_q;
    lwe_d   = lwe_q;
    d_d     = D;
    rd_d    = rd_out;
    we_d    = we_out;
    dv_d    = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (wb_sel_t'(sel) == WB_MEM) begin
            size_d  = ld_size;
            addr_d  = addr_lo;
            uns_d   = ld_uns;
            lrd_d   = rd_in;
            lwe_d   = we_in;
            cnt_d   = '0;
            state_d = WAIT_MEM;
          end else begin
            d_d  = sel_val;
            rd_d = rd_in;
            we_d = we_in;
            dv_d = 1'b1;
          end
        end
      end
      WAIT_MEM: begin
        cnt_d = cnt_q + 8'd1;
        // A response on the timeout cycle still completes the load normally.
        if (dm_valid) begin
          dv_d    = 1'b1;
          rd_d    = lrd_q;
          state_d = IDLE;
          if (misalign) begin
            d_d   = '0;
            we_d  = 1'b0;
            err_d = 1'b1;
          end else begin
            d_d  = ext_q;
            we_d = lwe_q;
          end
        end else if (cnt_q == 8'(TMO)) begin
          dv_d    = 1'b1;
          err_d   = 1'b1;
          d_d     = '0;
          we_d    = 1'b0;
          rd_d    = lrd_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      size_q  <= '0;
      addr_q  <= '0;
      uns_q   <= 1'b0;
      lrd_q   <= '0;
      lwe_q   <= 1'b0;
      D       <= '0;
      rd_out  <= '0;
      we_out  <= 1'b0;
      D_valid <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      uns_q   <= uns_d;
      lrd_q   <= lrd_d;
      lwe_q   <= lwe_d;
      D       <= d_d;
      rd_out  <= rd_d;
      we_out  <= we_d;
      D_valid <= dv_d;
      err     <= err_d;
    end
  end

endmodule
